// File: rtl/memory_writer.sv
// Burst write controller: takes words over a valid/ready stream and drives a registered RAM write port.
// Optional XOR checksum of accepted words when MEMORY_WRITER_CHECKSUM_EN is defined.
module memory_writer #(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   length,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_data,
  output logic               mem_we,
  output logic               busy,
  output logic               done
`ifdef MEMORY_WRITER_CHECKSUM_EN
  ,
  output logic [D_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] ptr;
  logic [A_WIDTH:0]   cnt;
  logic               hs;
  logic               start_ok;

  assign in_ready = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign hs       = in_valid & in_ready;
  assign start_ok = (state == IDLE) & start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? DONE : WRITE;
      WRITE:   if (hs && cnt == (A_WIDTH+1)'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write port is registered: a handshake at t shows up on mem_* at t+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= hs;
      if (start_ok) begin
        ptr <= base_addr;
        cnt <= length;
      end
      if (hs) begin
        mem_addr <= ptr;
        mem_data <= in_data;
        ptr      <= ptr + 1'b1;
        cnt      <= cnt - 1'b1;
      end
    end
  end

`ifdef MEMORY_WRITER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (hs)       checksum <= checksum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer: expected writes are queued when driven and checked when mem_we fires.
module tb_memory_writer;
  localparam int A_WIDTH = 4;
  localparam int D_WIDTH = 48;

  logic               clk = 1'b0;
  logic               rst_n, start, in_valid;
  logic [A_WIDTH-1:0] base_addr;
  logic [A_WIDTH:0]   length;
  logic [D_WIDTH-1:0] in_data;
  logic               in_ready, mem_we, busy, done;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_data;
`ifdef MEMORY_WRITER_CHECKSUM_EN
  logic [D_WIDTH-1:0] checksum;
`endif

  memory_writer #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .done(done)
`ifdef MEMORY_WRITER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [A_WIDTH-1:0] a;
    logic [D_WIDTH-1:0] d;
    int                 c;
    bit                 last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [A_WIDTH-1:0] b, input logic [A_WIDTH:0] l);
    start = 1'b1; base_addr = b; length = l;
    chk("ready_idle", 64'(in_ready), 64'd0);
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [A_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d, input bit last);
    exp_t e;
    in_valid = 1'b1; in_data = d;
    chk("ready_write", 64'(in_ready), 64'd1);
    e.a = a; e.d = d; e.c = cyc + 1; e.last = last;
    q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data  = D_WIDTH'({$urandom, $urandom});
    step();
  endtask

  // Scoreboard: every write strobe must match the oldest queued word.
  always @(negedge clk) begin
    if (mem_we) begin
      if (q.size() == 0) begin
        chk("spurious_we", 64'(mem_we), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("we_addr", 64'(mem_addr), 64'(e.a));
        chk("we_data", 64'(mem_data), 64'(e.d));
        chk("we_cycle", 64'(cyc), 64'(e.c));
        chk("we_done", 64'(done), 64'(e.last));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    base_addr = '0; length = '0; in_data = '0;
    step(); step();
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we",    64'(mem_we),   64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    chk("rst_data",  64'(mem_data), 64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_done",  64'(done),     64'd0);
    rst_n = 1'b1;
    step();

    // basic burst; word presented with start must wait for WRITE
    in_valid = 1'b1; in_data = 48'hA;
    do_start(4'd3, 5'd3);
    send(4'd3, 48'hA, 1'b0);
    send(4'd4, 48'hB, 1'b0);
    send(4'd5, 48'hC, 1'b1);
    chk("basic_busy_done", 64'(busy), 64'd1);
    step();
    chk("basic_idle", 64'(busy), 64'd0);

    // wrap-around
    do_start(4'd14, 5'd4);
    send(4'd14, 48'h1111, 1'b0);
    send(4'd15, 48'h2222, 1'b0);
    send(4'd0,  48'h3333, 1'b0);
    send(4'd1,  48'h4444, 1'b1);
    step();
    chk("wrap_idle", 64'(busy), 64'd0);

    // gaps 1,0,0,1,0,1
    do_start(4'd7, 5'd3);
    send(4'd7, 48'hDEAD_0001, 1'b0);
    gap(); gap();
    send(4'd8, 48'hDEAD_0002, 1'b0);
    gap();
    send(4'd9, 48'hDEAD_0003, 1'b1);
    step();
    chk("gap_idle", 64'(busy), 64'd0);

    // zero length
    do_start(4'd6, 5'd0);
    chk("zero_done", 64'(done),   64'd1);
    chk("zero_busy", 64'(busy),   64'd1);
    chk("zero_we",   64'(mem_we), 64'd0);
    step();
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_busy_end", 64'(busy), 64'd0);

    // start during WRITE is ignored
    do_start(4'd0, 5'd4);
    send(4'd0, 48'h5000, 1'b0);
    start = 1'b1; base_addr = 4'd9; length = 5'd2;
    send(4'd1, 48'h5001, 1'b0);
    start = 1'b0;
    send(4'd2, 48'h5002, 1'b0);
    send(4'd3, 48'h5003, 1'b1);
    step();
    chk("ign_idle", 64'(busy), 64'd0);

    // full-depth burst visits every location once
    do_start(4'd5, 5'd16);
    for (int i = 0; i < 16; i++)
      send(4'((5 + i) % 16), D_WIDTH'({$urandom, $urandom}), i == 15);
    step();
    chk("full_idle", 64'(busy), 64'd0);

    // reset mid-burst
    do_start(4'd2, 5'd5);
    send(4'd2, 48'h7002, 1'b0);
    send(4'd3, 48'h7003, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mrst_busy",  64'(busy),     64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd0);
    chk("mrst_we",    64'(mem_we),   64'd0);
    chk("mrst_addr",  64'(mem_addr), 64'd0);
    chk("mrst_data",  64'(mem_data), 64'd0);
    chk("mrst_done",  64'(done),     64'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 48'h7004;
    step(); step(); step();
    in_valid = 1'b0;
    chk("mrst_stay_idle", 64'(busy), 64'd0);

`ifdef MEMORY_WRITER_CHECKSUM_EN
    do_start(4'd0, 5'd3);
    send(4'd0, 48'h0F, 1'b0);
    send(4'd1, 48'hF0, 1'b0);
    send(4'd2, 48'h33, 1'b1);
    step();
    chk("csum_hold", 64'(checksum), 64'hCC);
    do_start(4'd0, 5'd1);
    chk("csum_clear", 64'(checksum), 64'd0);
    send(4'd0, 48'h5, 1'b1);
    step();
    chk("csum_single", 64'(checksum), 64'h5);
`endif

    step(); step();
    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_writer.md
Name: memory_writer

Overview:
- Write-side controller for the synchronous memory blocks: accepts a burst of data words over a valid/ready stream and drives a registered write port (address, data, write enable) into a RAM of depth 2**A_WIDTH.
- It is the loading counterpart to the read-enable ROM/RAM readers. The same A_WIDTH/D_WIDTH parameters apply, so it can be placed directly in front of a memory instance.

Parameters:
- A_WIDTH, 4, memory address width; addressable depth 2**A_WIDTH.
- D_WIDTH, 48, data word width.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
- base_addr  input  A_WIDTH  first write address; latched on an accepted start.
- length  input  A_WIDTH+1  number of words in the burst, 0..2**A_WIDTH; latched on an accepted start.
- in_valid  input  1  source has a word on in_data.
- in_data  input  D_WIDTH  word to write.
- in_ready  output  1  writer accepts a word this cycle.
- mem_addr  output  A_WIDTH  registered write address.
- mem_data  output  D_WIDTH  registered write data.
- mem_we  output  1  registered write-enable strobe, one cycle per word.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst_n=0 at a clk edge) is honoured in any state, including mid-burst. Resulting values:
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0.
  - Internal address and count registers = 0.
  - Words not yet written are discarded.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start=1: latch base_addr into the address pointer and length into the remaining count.
  - If length!=0, next state is WRITE. If length==0, next state is DONE (no mem_we pulses).
- WRITE:
  - in_ready=1, driven combinationally from state.
  - A handshake is in_valid & in_ready. On a handshake, the next cycle has mem_we=1, mem_addr=pointer and mem_data=in_data.
  - On a handshake, the pointer increments modulo 2**A_WIDTH (wraps from 2**A_WIDTH-1 to 0) and the count decrements.
  - No handshake: mem_we=0 the next cycle; mem_addr and mem_data hold their values.
  - Handshake with count==1: next state is DONE.
  - Full throughput: one word per cycle while in_valid stays high.
- DONE:
  - Lasts exactly one cycle; done=1, in_ready=0. Next state is IDLE.
  - The final word's mem_we pulse coincides with the done cycle.
- Latency: handshake at cycle t gives mem_we at t+1. The last handshake at t gives done at t+1, and IDLE (busy=0) at t+2.
- busy=1 in WRITE and DONE, 0 in IDLE.
- A start arriving in WRITE or DONE is ignored, with no effect on the latched values.
- start and in_valid in the same IDLE cycle: the word is not accepted (in_ready=0); the source must hold it.
- length==2**A_WIDTH: writes every location exactly once, starting from base_addr and wrapping.
- in_valid may toggle freely in WRITE. Gaps stall the burst and produce no spurious mem_we.

Optional Feature:
- Macro: MEMORY_WRITER_CHECKSUM_EN.
- When defined, adds output checksum [D_WIDTH-1:0], the XOR of all words accepted in the current burst:
  - Cleared to 0 on reset and on an accepted start.
  - Updated on each handshake, visible from t+1.
  - Holds its value after done until the next accepted start.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst: start base_addr=2, length=5, accept 2 words, then rst_n=0 for 1 cycle -> all outputs 0 and state IDLE next cycle; no further mem_we after reset.
- Basic burst: start base_addr=3, length=3, in_valid held high with data 0xA,0xB,0xC -> mem_we high 3 consecutive cycles at addr 3,4,5 with data A,B,C; done pulse coincides with the write to addr 5; busy low the next cycle.
- Wrap-around at A_WIDTH=4: base_addr=14, length=4 -> writes to addr 14,15,0,1 in order.
- Backpressure gaps: length=3, in_valid pattern 1,0,0,1,0,1 -> exactly 3 mem_we pulses, each one cycle after its handshake; done one cycle after the third handshake.
- Zero length and ignored start: start with length=0 -> no mem_we, done at t+1, busy high only in the DONE cycle. Separately, start during WRITE with new base_addr=9 -> ignored; addresses continue from the original pointer.
- With MEMORY_WRITER_CHECKSUM_EN: burst of 0x0F, 0xF0, 0x33 -> checksum=0xCC after done; next start clears it to 0.
